uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 19 +
 rtl/rr_priority_picker.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared state encoding, defaults and width helper for the UART TX arbiter
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_RFN_TIMEOUT = 16;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin pick: first set request at or above ptr, wrapping
module rr_priority_picker
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int OW   = owner_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [OW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [OW-1:0]    o_idx,
    output logic             o_any
);

    logic [OW-1:0] cand;

    // Walk downward in distance from ptr so the nearest requester is written last and wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        cand     = '0;
        o_any    = |i_req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = OW'((int'(i_ptr) + k) % N_REQ);
            if (i_req[cand]) begin
                o_idx    = cand;
                o_onehot = N_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter with packet lock feeding one UART transmitter
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RFN_TIMEOUT = DEF_RFN_TIMEOUT,
    localparam int OW         = owner_w(N_REQ),
    localparam int CW         = $clog2(RFN_TIMEOUT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ-1:0]        i_lock,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    output logic [N_REQ-1:0]        o_gnt,
    input  logic                    i_RFN,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_nTx_EN,
    output logic [OW-1:0]           o_owner,
    output logic                    o_busy
);

    arb_state_t    state;
    logic [OW-1:0] ptr;
    logic          lock_hold;
    logic [CW-1:0] cnt;

    logic [N_REQ-1:0]  pick_onehot;
    logic [OW-1:0]     pick_idx;
    logic              pick_any;
    logic              owner_wins;
    logic [OW-1:0]     win_idx;
    logic [DATA_W-1:0] win_byte;

    rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
        .i_req   (i_req),
        .i_ptr   (ptr),
        .o_onehot(pick_onehot),
        .o_idx   (pick_idx),
        .o_any   (pick_any)
    );

    assign owner_wins = lock_hold && i_req[o_owner];
    assign win_idx    = owner_wins ? o_owner : pick_idx;
    assign win_byte   = i_data[int'(win_idx)*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            lock_hold <= 1'b0;
            cnt       <= '0;
            o_gnt     <= '0;
            o_data    <= '0;
            o_nTx_EN  <= 1'b1;
            o_owner   <= '0;
            o_busy    <= 1'b0;
        end else begin
            o_gnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (i_RFN && pick_any) begin
                        if (!owner_wins) begin
                            lock_hold <= 1'b0;
                        end
                        o_gnt   <= owner_wins ? (N_REQ'(1) << o_owner) : pick_onehot;
                        o_data  <= win_byte;
                        o_owner <= win_idx;
                        cnt     <= '0;
                        o_busy  <= 1'b1;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    // Strobe drops one cycle after the grant; RFN only counts while it is low.
                    if (o_nTx_EN) begin
                        o_nTx_EN <= 1'b0;
                        cnt      <= '0;
                    end else if (!i_RFN) begin
                        o_nTx_EN <= 1'b1;
                        state    <= ST_WAIT_DONE;
                    end else if (cnt == CW'(RFN_TIMEOUT - 1)) begin
                        o_nTx_EN <= 1'b1;
                        state    <= ST_WAIT_BUSY;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_WAIT_BUSY: begin
                    o_nTx_EN <= 1'b0;
                    cnt      <= '0;
                    state    <= ST_START;
                end
                ST_WAIT_DONE: begin
                    if (i_RFN) begin
                        o_busy    <= 1'b0;
                        ptr       <= (o_owner == OW'(N_REQ - 1)) ? '0 : o_owner + OW'(1);
                        lock_hold <= i_lock[o_owner];
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
